cache_wb_direct: RTL and testbench
==================================

CACHE_WB_DIRECT -- requirements
Module: cache_wb_direct

Interface
REQ-001 Parameter ADDR_W, default 12, byte-address width (4096-byte memory).
REQ-002 Parameter DATA_W, default 32, word width in bits.
REQ-003 Parameter NUM_LINES, default 32, cache lines (power of two, >=2).
REQ-004 Parameter WORDS_PER_LINE, default 4, words per line (power of two, >=2).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 cpu_req  input  1  CPU access request, held until cpu_ready.
REQ-008 cpu_we  input  1  1 = write, 0 = read.
REQ-009 cpu_addr  input  ADDR_W  byte address, word-aligned (low 2 bits ignored).
REQ-010 cpu_wdata  input  DATA_W  write data.
REQ-011 cpu_rdata  output  DATA_W  read data, valid when cpu_ready && !cpu_we.
REQ-012 cpu_ready  output  1  access completes this cycle.
REQ-013 mem_req  output  1  memory block request, held until mem_ready.
REQ-014 mem_we  output  1  1 = block write-back, 0 = block fetch.
REQ-015 mem_addr  output  ADDR_W  line-aligned byte address.
REQ-016 mem_wblock  output  DATA_W*WORDS_PER_LINE  victim line for write-back.
REQ-017 mem_rblock  input  DATA_W*WORDS_PER_LINE  fetched line, valid with mem_ready.
REQ-018 mem_ready  input  1  memory completes current request this cycle.

Function
REQ-019 Address split, LSB up: 2 byte bits, log2(WORDS_PER_LINE) word-offset bits, log2(NUM_LINES) index bits, remaining bits tag.
REQ-020 Storage: data array NUM_LINES*WORDS_PER_LINE words, per-line tag, valid bit, dirty bit; direct-mapped.
REQ-021 Line packing on both memory buses: word offset 0 in the most-significant DATA_W bits, offset WORDS_PER_LINE-1 in the LSBs.
REQ-022 FSM states IDLE, WRITEBACK, REFILL; transitions only on rising clk.
REQ-023 Hit = cpu_req && valid[index] && tag[index]==addr tag, evaluated in IDLE only.
REQ-024 Read hit: cpu_ready=1 and cpu_rdata=addressed word combinationally in the same cycle (zero-wait).
REQ-025 Write hit: cpu_ready=1 same cycle; word written and dirty[index] set at that rising edge.
REQ-026 Miss in IDLE with valid&&dirty victim -> WRITEBACK; otherwise -> REFILL; cpu_ready=0.
REQ-027 WRITEBACK: mem_req=1, mem_we=1, mem_addr={victim tag,index,0s}, mem_wblock=victim line; on mem_ready -> REFILL.
REQ-028 REFILL: mem_req=1, mem_we=0, mem_addr={cpu tag,index,0s}; on mem_ready whole line, tag written, valid=1, dirty=0, -> IDLE.
REQ-029 After REFILL the held request re-evaluates in IDLE and hits; miss latency = memory cycles + 1; write miss is write-allocate.
REQ-030 mem_addr, mem_we, mem_wblock stable while mem_req=1; all mem outputs 0 in IDLE.
REQ-031 cpu_req dropped mid-miss: current WRITEBACK/REFILL completes; no CPU word written.
REQ-032 cpu_ready=0 and cpu_rdata=0 outside IDLE-hit and on write accesses.
REQ-033 mem_ready outside WRITEBACK/REFILL ignored.

Reset
REQ-034 rst_n low: state=IDLE, all valid and dirty bits=0, all outputs 0 immediately; tags/data not reset.
REQ-035 Reset mid-WRITEBACK/REFILL aborts the transfer; mem_req drops asynchronously; no array update.

Verification (defaults: tag=addr[11:9], index=addr[8:4], offset=addr[3:2])
REQ-036 After reset, read 0x010 -> REFILL, mem_addr=0x010, mem_we=0; mem_rblock=128'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3, mem_ready 1 cycle -> next cycle cpu_ready=1, cpu_rdata=32'hA0A0A0A0.
REQ-037 Then read 0x01C -> same-cycle cpu_ready=1, cpu_rdata=32'hD3D3D3D3, mem_req stays 0.
REQ-038 Write 0x014 data 32'h12345678 -> same-cycle cpu_ready; then read 0x210 -> WRITEBACK mem_addr=0x010, mem_wblock=128'hA0A0A0A0_12345678_C2C2C2C2_D3D3D3D3, then REFILL mem_addr=0x210.
REQ-039 Write miss 0x420 after reset -> REFILL 0x420 (no WRITEBACK), then write completes; subsequent read 0x420 returns written data, dirty set.
REQ-040 Assert rst_n low during REFILL with mem_ready held low -> mem_req=0 immediately; after release read 0x010 misses again.
REQ-041 mem_ready delayed 5 cycles -> mem_req, mem_addr stable for all 5 cycles, cpu_ready=0 throughout.

Source files
------------

// File: rtl/cache_wb_direct_if.sv
// cache_wb_direct_if: CPU-side and memory-side bus bundle for the write-back cache.
interface cache_wb_direct_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int WORDS_PER_LINE = 4
);
  logic                             cpu_req;
  logic                             cpu_we;
  logic [ADDR_W-1:0]                cpu_addr;
  logic [DATA_W-1:0]                cpu_wdata;
  logic [DATA_W-1:0]                cpu_rdata;
  logic                             cpu_ready;
  logic                             mem_req;
  logic                             mem_we;
  logic [ADDR_W-1:0]                mem_addr;
  logic [DATA_W*WORDS_PER_LINE-1:0] mem_wblock;
  logic [DATA_W*WORDS_PER_LINE-1:0] mem_rblock;
  logic                             mem_ready;
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rblock, mem_ready,
    input  cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wblock
  );
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rblock, mem_ready,
    output cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wblock
  );
endinterface

// File: rtl/cache_wb_direct.sv
// cache_wb_direct: direct-mapped write-back, write-allocate cache with zero-wait hits.
module cache_wb_direct #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int NUM_LINES = 32,
  parameter int WORDS_PER_LINE = 4
) (
  input logic clk,
  input logic rst_n,
  cache_wb_direct_if.slave bus
);
  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WRITEBACK = 2'd1;
  localparam logic [1:0] REFILL = 2'd2;
  logic [1:0] state;
  logic [NUM_LINES-1:0] valid, dirty;
  logic [TAG_W-1:0] tag_mem [NUM_LINES];
  logic [DATA_W-1:0] data_mem [NUM_LINES*WORDS_PER_LINE];
  logic [TAG_W-1:0] m_tag;
  logic [IDX_W-1:0] m_idx;
  logic [DATA_W*WORDS_PER_LINE-1:0] victim;
  logic [TAG_W-1:0] a_tag;
  logic [IDX_W-1:0] a_idx;
  logic [OFF_W-1:0] a_off;
  logic hit, wr_hit, miss, fill, unused_ok;
  assign a_off = bus.cpu_addr[2 +: OFF_W];
  assign a_idx = bus.cpu_addr[2+OFF_W +: IDX_W];
  assign a_tag = bus.cpu_addr[ADDR_W-1 -: TAG_W];
  assign unused_ok = ^bus.cpu_addr[1:0];
  assign hit = rst_n && state == IDLE && bus.cpu_req && valid[a_idx] && tag_mem[a_idx] == a_tag;
  assign wr_hit = hit && bus.cpu_we;
  assign miss = state == IDLE && bus.cpu_req && !hit;
  assign fill = state == REFILL && bus.mem_ready;
  assign bus.cpu_ready = hit;
  assign bus.cpu_rdata = hit && !bus.cpu_we ? data_mem[{a_idx, a_off}] : '0;
  // Memory-side outputs come only from latched miss state so they stay stable even if the CPU lets go.
  assign bus.mem_req = state != IDLE;
  assign bus.mem_we = state == WRITEBACK;
  assign bus.mem_addr = state == WRITEBACK ? {tag_mem[m_idx], m_idx, {(OFF_W+2){1'b0}}} :
                        state == REFILL ? {m_tag, m_idx, {(OFF_W+2){1'b0}}} : '0;
  assign bus.mem_wblock = state == WRITEBACK ? victim : '0;
  always_comb begin
    victim = '0;
    for (int w = 0; w < WORDS_PER_LINE; w++)
      victim[(WORDS_PER_LINE-1-w)*DATA_W +: DATA_W] = data_mem[{m_idx, OFF_W'(w)}];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      valid <= '0;
      dirty <= '0;
    end else begin
      if (wr_hit) dirty[a_idx] <= 1'b1;
      if (miss) state <= valid[a_idx] && dirty[a_idx] ? WRITEBACK : REFILL;
      if (state == WRITEBACK && bus.mem_ready) state <= REFILL;
      if (fill) begin
        valid[m_idx] <= 1'b1;
        dirty[m_idx] <= 1'b0;
        state <= IDLE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (miss) begin
      m_tag <= a_tag;
      m_idx <= a_idx;
    end
    if (wr_hit) data_mem[{a_idx, a_off}] <= bus.cpu_wdata;
    if (fill) begin
      for (int w = 0; w < WORDS_PER_LINE; w++)
        data_mem[{m_idx, OFF_W'(w)}] <= bus.mem_rblock[(WORDS_PER_LINE-1-w)*DATA_W +: DATA_W];
      tag_mem[m_idx] <= m_tag;
    end
  end
endmodule

// File: tb/tb_cache_wb_direct.sv
// tb_cache_wb_direct: directed scenarios for the direct-mapped write-back cache.
module tb_cache_wb_direct;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  cache_wb_direct_if #(.ADDR_W(12), .DATA_W(32), .WORDS_PER_LINE(4)) bus ();
  cache_wb_direct #(.ADDR_W(12), .DATA_W(32), .NUM_LINES(32), .WORDS_PER_LINE(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #2;
  endtask
  task automatic req(input logic we, input logic [11:0] addr, input logic [31:0] wd);
    bus.cpu_req = 1'b1;
    bus.cpu_we = we;
    bus.cpu_addr = addr;
    bus.cpu_wdata = wd;
    #1;
  endtask
  task automatic mem_resp(input logic rdy, input logic [127:0] blk);
    bus.mem_ready = rdy;
    bus.mem_rblock = blk;
  endtask
  task automatic do_reset;
    bus.cpu_req = 1'b0;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_wdata = '0;
    mem_resp(1'b0, '0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask
  task automatic test_reset;
    bus.cpu_req = 1'b1;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = 12'h010;
    bus.cpu_wdata = '0;
    mem_resp(1'b1, '0);
    rst_n = 1'b0;
    #1;
    total++; if (bus.cpu_ready !== 1'b0) begin bad++; $display("FAIL reset_cpu_ready got=%b exp=0", bus.cpu_ready); end
    total++; if (bus.cpu_rdata !== 32'h0) begin bad++; $display("FAIL reset_cpu_rdata got=%h exp=0", bus.cpu_rdata); end
    total++; if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== 14'h0) begin bad++; $display("FAIL reset_mem_ctl got=%h exp=0", {bus.mem_req, bus.mem_we, bus.mem_addr}); end
    total++; if (bus.mem_wblock !== 128'h0) begin bad++; $display("FAIL reset_wblock got=%h exp=0", bus.mem_wblock); end
    do_reset();
  endtask
  task automatic test_read_miss;
    req(1'b0, 12'h010, 32'h0);
    total++; if ({bus.cpu_ready, bus.mem_req} !== 2'b00) begin bad++; $display("FAIL rmiss_idle got=%b exp=00", {bus.cpu_ready, bus.mem_req}); end
    step();
    total++; if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {2'b10, 12'h010}) begin bad++; $display("FAIL rmiss_refill got=%h exp=%h", {bus.mem_req, bus.mem_we, bus.mem_addr}, {2'b10, 12'h010}); end
    total++; if (bus.cpu_ready !== 1'b0) begin bad++; $display("FAIL rmiss_wait_ready got=%b exp=0", bus.cpu_ready); end
    mem_resp(1'b1, 128'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3);
    step();
    mem_resp(1'b0, '0);
    #1;
    total++; if ({bus.cpu_ready, bus.cpu_rdata} !== {1'b1, 32'hA0A0A0A0}) begin bad++; $display("FAIL rmiss_data got=%h exp=%h", {bus.cpu_ready, bus.cpu_rdata}, {1'b1, 32'hA0A0A0A0}); end
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL rmiss_memidle got=%b exp=0", bus.mem_req); end
  endtask
  task automatic test_read_hit;
    req(1'b0, 12'h01C, 32'h0);
    total++; if ({bus.cpu_ready, bus.cpu_rdata} !== {1'b1, 32'hD3D3D3D3}) begin bad++; $display("FAIL rhit_data got=%h exp=%h", {bus.cpu_ready, bus.cpu_rdata}, {1'b1, 32'hD3D3D3D3}); end
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL rhit_memreq got=%b exp=0", bus.mem_req); end
    step();
  endtask
  task automatic test_writeback;
    req(1'b1, 12'h014, 32'h12345678);
    total++; if ({bus.cpu_ready, bus.cpu_rdata} !== {1'b1, 32'h0}) begin bad++; $display("FAIL whit got=%h exp=%h", {bus.cpu_ready, bus.cpu_rdata}, {1'b1, 32'h0}); end
    step();
    req(1'b0, 12'h210, 32'h0);
    total++; if (bus.cpu_ready !== 1'b0) begin bad++; $display("FAIL wb_miss_ready got=%b exp=0", bus.cpu_ready); end
    mem_resp(1'b1, 128'hDEAD_BEEF);
    step();
    total++; if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {2'b11, 12'h010}) begin bad++; $display("FAIL wb_ctl got=%h exp=%h", {bus.mem_req, bus.mem_we, bus.mem_addr}, {2'b11, 12'h010}); end
    total++; if (bus.mem_wblock !== 128'hA0A0A0A0_12345678_C2C2C2C2_D3D3D3D3) begin bad++; $display("FAIL wb_block got=%h exp=%h", bus.mem_wblock, 128'hA0A0A0A0_12345678_C2C2C2C2_D3D3D3D3); end
    mem_resp(1'b1, 128'h11111111_22222222_33333333_44444444);
    step();
    total++; if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {2'b10, 12'h210}) begin bad++; $display("FAIL wb_refill got=%h exp=%h", {bus.mem_req, bus.mem_we, bus.mem_addr}, {2'b10, 12'h210}); end
    total++; if (bus.mem_wblock !== 128'h0) begin bad++; $display("FAIL wb_refill_wblock got=%h exp=0", bus.mem_wblock); end
    step();
    mem_resp(1'b0, '0);
    #1;
    total++; if ({bus.cpu_ready, bus.cpu_rdata} !== {1'b1, 32'h11111111}) begin bad++; $display("FAIL wb_after got=%h exp=%h", {bus.cpu_ready, bus.cpu_rdata}, {1'b1, 32'h11111111}); end
    step();
  endtask
  task automatic test_write_miss;
    do_reset();
    req(1'b1, 12'h420, 32'hCAFEF00D);
    step();
    total++; if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {2'b10, 12'h420}) begin bad++; $display("FAIL wmiss_refill got=%h exp=%h", {bus.mem_req, bus.mem_we, bus.mem_addr}, {2'b10, 12'h420}); end
    mem_resp(1'b1, 128'h01010101_02020202_03030303_04040404);
    step();
    mem_resp(1'b0, '0);
    #1;
    total++; if ({bus.cpu_ready, bus.cpu_rdata, bus.mem_req} !== {1'b1, 32'h0, 1'b0}) begin bad++; $display("FAIL wmiss_done got=%h exp=%h", {bus.cpu_ready, bus.cpu_rdata, bus.mem_req}, {1'b1, 32'h0, 1'b0}); end
    step();
    req(1'b0, 12'h420, 32'h0);
    total++; if ({bus.cpu_ready, bus.cpu_rdata} !== {1'b1, 32'hCAFEF00D}) begin bad++; $display("FAIL wmiss_read got=%h exp=%h", {bus.cpu_ready, bus.cpu_rdata}, {1'b1, 32'hCAFEF00D}); end
    step();
    req(1'b0, 12'h020, 32'h0);
    step();
    total++; if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {2'b11, 12'h420}) begin bad++; $display("FAIL wmiss_dirty got=%h exp=%h", {bus.mem_req, bus.mem_we, bus.mem_addr}, {2'b11, 12'h420}); end
    total++; if (bus.mem_wblock !== 128'hCAFEF00D_02020202_03030303_04040404) begin bad++; $display("FAIL wmiss_wblock got=%h exp=%h", bus.mem_wblock, 128'hCAFEF00D_02020202_03030303_04040404); end
  endtask
  task automatic test_reset_mid_refill;
    do_reset();
    req(1'b0, 12'h010, 32'h0);
    step();
    total++; if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL rst_refill_req got=%b exp=1", bus.mem_req); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if ({bus.mem_req, bus.mem_addr, bus.cpu_ready} !== 14'h0) begin bad++; $display("FAIL rst_async got=%h exp=0", {bus.mem_req, bus.mem_addr, bus.cpu_ready}); end
    step();
    rst_n = 1'b1;
    #1;
    total++; if (bus.cpu_ready !== 1'b0) begin bad++; $display("FAIL rst_remiss_ready got=%b exp=0", bus.cpu_ready); end
    step();
    total++; if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {2'b10, 12'h010}) begin bad++; $display("FAIL rst_remiss got=%h exp=%h", {bus.mem_req, bus.mem_we, bus.mem_addr}, {2'b10, 12'h010}); end
  endtask
  task automatic test_delayed_ready;
    for (int c = 0; c < 5; c++) begin
      step();
      total++; if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.cpu_ready} !== {2'b10, 12'h010, 1'b0}) begin bad++; $display("FAIL delay_hold%0d got=%h exp=%h", c, {bus.mem_req, bus.mem_we, bus.mem_addr, bus.cpu_ready}, {2'b10, 12'h010, 1'b0}); end
    end
    mem_resp(1'b1, 128'h55555555_66666666_77777777_88888888);
    step();
    mem_resp(1'b0, '0);
    #1;
    total++; if ({bus.cpu_ready, bus.cpu_rdata} !== {1'b1, 32'h55555555}) begin bad++; $display("FAIL delay_data got=%h exp=%h", {bus.cpu_ready, bus.cpu_rdata}, {1'b1, 32'h55555555}); end
    step();
  endtask
  task automatic test_drop_mid_miss;
    req(1'b1, 12'h030, 32'hBADBAD00);
    step();
    bus.cpu_req = 1'b0;
    bus.cpu_addr = 12'hFFC;
    #1;
    total++; if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {2'b10, 12'h030}) begin bad++; $display("FAIL drop_addr got=%h exp=%h", {bus.mem_req, bus.mem_we, bus.mem_addr}, {2'b10, 12'h030}); end
    mem_resp(1'b1, 128'h9A9A9A9A_8B8B8B8B_7C7C7C7C_6D6D6D6D);
    step();
    mem_resp(1'b1, '0);
    #1;
    total++; if ({bus.mem_req, bus.cpu_ready} !== 2'b00) begin bad++; $display("FAIL drop_idle got=%b exp=00", {bus.mem_req, bus.cpu_ready}); end
    step();
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL idle_memready got=%b exp=0", bus.mem_req); end
    mem_resp(1'b0, '0);
    req(1'b0, 12'h030, 32'h0);
    total++; if ({bus.cpu_ready, bus.cpu_rdata} !== {1'b1, 32'h9A9A9A9A}) begin bad++; $display("FAIL drop_nowrite got=%h exp=%h", {bus.cpu_ready, bus.cpu_rdata}, {1'b1, 32'h9A9A9A9A}); end
    step();
  endtask
  initial begin
    test_reset();
    test_read_miss();
    test_read_hit();
    test_writeback();
    test_write_miss();
    test_reset_mid_refill();
    test_delayed_ready();
    test_drop_mid_miss();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
